seq_add48: RTL and testbench
============================

Name: seq_add48

Overview:
- Multi-cycle wide adder that feeds operand slices into one CLA_3b instance, 3 bits per cycle, LSB slice first.
- A registered carry links consecutive slices.
- Sits upstream of CLA_3b: it supplies the slice operands and carry-in, and consumes the slice sum and carry-out.
- Trades latency for area, versus a full-width CLA, in the SA48 datapath.

Parameters:
- WIDTH, 48, operand/result width. Must be a multiple of 3; checked by an elaboration-time assertion.
- NSLICE, WIDTH/3 (localparam), number of 3-bit slices, i.e. RUN cycles.

Ports:
- clk    input   1      rising-edge clock
- rst    input   1      synchronous, active-high reset
- start  input   1      request. A, B and Cin are sampled on the edge where start=1 and the block is not busy.
- A      input   WIDTH  operand A
- B      input   WIDTH  operand B
- Cin    input   1      carry-in to slice 0
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse: S and Co have just been updated
- S      output  WIDTH  registered sum of the last completed operation
- Co     output  1      registered carry-out of the last completed operation

Behaviour:
- Reset: synchronous, active-high on rst; it is the only reset.
  - State=IDLE; busy=0, done=0, S=0, Co=0; slice counter=0; carry register=0; operand registers=0.
- States: IDLE, RUN, DONE. Encoding is a package enum.
- IDLE
  - start=1: latch A and B into operand shift registers, latch Cin into the carry register, counter=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN
  - Each cycle, CLA_3b adds opA[2:0], opB[2:0] and the carry register.
  - The 3-bit sum is shifted into the top of the accumulation register; it is right-shifted by 3, so slice 0 ends up at bits 2:0.
  - The carry register takes the CLA_3b Co.
  - opA and opB are right-shifted by 3.
  - counter increments.
  - When counter==NSLICE-1 in RUN: on that edge, S<=final accumulation, Co<=slice Co, go to DONE.
- DONE
  - done=1 for exactly this one cycle.
  - start=1 in DONE is accepted, with the same actions as IDLE, next state RUN. Otherwise go to IDLE.
- Latency
  - Start sampled at edge 0; busy=1 during cycles 1..NSLICE; done=1 in cycle NSLICE+1.
  - Throughput: one operation per NSLICE+1 cycles (back-to-back via DONE).
- start while busy: ignored. No queueing and no error flag; operands keep their latched values.
- S and Co hold their values from one done until the next done. They never show partial sums.
- Arithmetic is unsigned modulo 2^WIDTH; Co is bit WIDTH of A+B+Cin.
  - A and B changing after the start edge do not affect the result.
- rst asserted mid-RUN: the operation is aborted, everything returns to reset values (S=0), and done is not pulsed.
- busy and done are mutually exclusive and never high in the same cycle.

Optional Feature:
- Macro: SEQ_ADD48_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), registered and updated only with S/Co; reset 0.
  - ovf = (A[WIDTH-1]==B[WIDTH-1]) && (S[WIDTH-1]!=A[WIDTH-1]), using the latched operand MSBs. This is two's-complement signed overflow.
- Undefined: no ovf port and no extra MSB registers; behaviour otherwise identical.

Decomposition:
- Package seq_add_pkg:
  - state enum (IDLE, RUN, DONE)
  - SLICE_W=3 constant
  - function computing the counter width $clog2(NSLICE)
- Sub-module: the existing CLA_3b is instantiated once as the slice adder. No new sub-module.
- FSM, counter and shift registers live in seq_add48.

Test Plan:
- Reset, then A=0x000000000001, B=0x000000000002, Cin=0, start pulse -> done in cycle 17 after start; S=0x000000000003; Co=0; busy high exactly 16 cycles.
- A=0xFFFFFFFFFFFF, B=0x000000000000, Cin=1 -> S=0x000000000000, Co=1 (carry ripples through all 16 slices).
- A=0x800000000000, B=0x800000000000, Cin=0 -> S=0, Co=1. With SEQ_ADD48_OVF_EN, ovf=1. A=0x7FFFFFFFFFFF, B=1 -> S=0x800000000000, Co=0, ovf=1.
- Start held high in the DONE cycle with new operands A=5, B=7 -> the second op begins with no IDLE gap; S holds the old sum until the second done shows S=12. Start pulses during RUN are ignored.
- rst asserted at cycle 8 of RUN -> S=0, Co=0, busy=0, no done pulse. The next start with A=0x123456789ABC, B=0x111111111111 -> S=0x23456789ABCD truncated to 0x23456789ABCD, Co=0.
- Random unsigned pairs (≥1000) with random Cin and random start gaps vs the reference model {Co,S}=A+B+Cin -> all match; done count equals accepted-start count.

Source files
------------

// File: rtl/seq_add_pkg.sv
// Shared types and constants for the sequential slice adder.
package seq_add_pkg;
  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction
endpackage

// File: rtl/CLA_3b.sv
// 3-bit carry-lookahead adder used as the per-cycle slice adder.
module CLA_3b (
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       Cin,
  output logic [2:0] S,
  output logic       Co
);
  logic [2:0] g, p;
  logic c1, c2;

  assign g  = A & B;
  assign p  = A ^ B;
  assign c1 = g[0] | (p[0] & Cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign Co = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign S  = p ^ {c2, c1, Cin};
endmodule

// File: rtl/seq_add48.sv
// Multi-cycle WIDTH-bit adder: one 3-bit CLA slice per cycle, LSB first.
// Define SEQ_ADD48_OVF_EN to add the registered signed-overflow output ovf.
module seq_add48
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
`ifdef SEQ_ADD48_OVF_EN
  output logic             ovf,
`endif
  output logic             Co
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = cnt_w(NSLICE);
  localparam int ACC_W  = WIDTH - SLICE_W;

  generate
    if (WIDTH % SLICE_W != 0 || WIDTH < 2 * SLICE_W) begin : g_width_chk
      $error("seq_add48: WIDTH must be a multiple of 3 and at least 6");
    end
  endgenerate

  state_t state, state_nxt;

  logic [WIDTH-1:0]   opa, opb;
  logic [ACC_W-1:0]   acc;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_co;
  logic               accept, last;

  CLA_3b u_cla (
    .A   (opa[SLICE_W-1:0]),
    .B   (opb[SLICE_W-1:0]),
    .Cin (carry),
    .S   (sl_s),
    .Co  (sl_co)
  );

  // A new request is taken whenever the datapath is not mid-operation,
  // which includes the DONE cycle for back-to-back operation.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(NSLICE - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      Co    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opa   <= A;
        opb   <= B;
        carry <= Cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        opa   <= opa >> SLICE_W;
        opb   <= opb >> SLICE_W;
        carry <= sl_co;
        cnt   <= cnt + 1'b1;
        acc   <= {sl_s, acc[ACC_W-1:SLICE_W]};
        if (last) begin
          S  <= {sl_s, acc};
          Co <= sl_co;
        end
      end
    end
  end

`ifdef SEQ_ADD48_OVF_EN
  // Operand MSBs are captured at accept because opa/opb are shifted away.
  logic a_msb, b_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= A[WIDTH-1];
        b_msb <= B[WIDTH-1];
      end
      if (last) ovf <= (a_msb == b_msb) && (sl_s[SLICE_W-1] != a_msb);
    end
  end
`endif
endmodule

// File: tb/tb_seq_add48.sv
// Scoreboard bench for seq_add48: stimulus pushes expectations, monitor checks on done.
module tb_seq_add48;
  localparam int W = 48;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, Cin;
  logic [W-1:0] A, B;
  logic         busy, done, Co;
  logic [W-1:0] S;
`ifdef SEQ_ADD48_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   accepted = 0, dones = 0;

  always #5 clk = ~clk;

  seq_add48 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .S     (S),
`ifdef SEQ_ADD48_OVF_EN
    .ovf   (ovf),
`endif
    .Co    (Co)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) chk("busy_done_exclusive", 1, 0);
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("S", 64'(S), 64'(e.s));
          chk("Co", 64'(Co), 64'(e.co));
`ifdef SEQ_ADD48_OVF_EN
          chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
        end
      end
    end
  end

  // Waits (at a negedge) until the block can accept, then pulses start.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic eco, input logic eovf);
    int n = 0;
    exp_t e;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("accept_timeout", 1, 0);
    A = a; B = b; Cin = c; start = 1'b1;
    e.s = es; e.co = eco; e.ovf = eovf;
    @(posedge clk);
    sb.push_back(e);
    accepted++;
    @(negedge clk);
    start = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 1, 0);
  endtask

  task automatic issue_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    issue(a, b, c, sum[W-1:0], sum[W],
          (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]));
  endtask

  initial begin
    int cyc, bc;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_S", 64'(S), 0);
    chk("rst_Co", 64'(Co), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: busy for exactly 16 cycles, done in cycle 17.
    issue(48'h000000000001, 48'h000000000002, 1'b0, 48'h000000000003, 1'b0, 1'b0);
    cyc = 1; bc = 0;
    while (!done && cyc < 40) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
    chk("done_cycle", 64'(cyc), 17);
    chk("busy_cycles", 64'(bc), 16);
    @(negedge clk);

    issue(48'hFFFFFFFFFFFF, 48'h000000000000, 1'b1, 48'h000000000000, 1'b1, 1'b0);
    issue(48'h800000000000, 48'h800000000000, 1'b0, 48'h000000000000, 1'b1, 1'b1);
    issue(48'h7FFFFFFFFFFF, 48'h000000000001, 1'b0, 48'h800000000000, 1'b0, 1'b1);

    // Back-to-back from DONE; stray start during RUN must be ignored.
    wait_done();
    issue(48'h000000000005, 48'h000000000007, 1'b0, 48'h00000000000C, 1'b0, 1'b0);
    chk("no_idle_gap_busy", 64'(busy), 1);
    repeat (3) @(negedge clk);
    chk("S_holds_old", 64'(S), 64'h800000000000);
    A = 48'h99; B = 48'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = '0; B = '0;
    wait_done();
    @(negedge clk);

    // Abort mid-RUN: drop the expectation; any later done for it is flagged.
    issue(48'h111111111111, 48'h222222222222, 1'b0, 48'h333333333333, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    accepted--;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_S", 64'(S), 0);
    chk("abort_Co", 64'(Co), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    repeat (20) @(negedge clk);
    issue(48'h123456789ABC, 48'h111111111111, 1'b0, 48'h23456789ABCD, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      issue_model(a, b, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_done();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (25) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 0);
    chk("done_count", 64'(dones), 64'(accepted));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
